// File: rtl/frame_write_arbiter_if.sv
// Pixel-write arbiter bus: two pixel requesters, the clear engine controls,
// the blanking indication and the draw-frame write port.
interface frame_write_arbiter_if;
   logic        active_pixels;

   logic        req0_valid;
   logic [7:0]  req0_x;
   logic [6:0]  req0_y;
   logic [23:0] req0_color;
   logic        req0_ready;

   logic        req1_valid;
   logic [7:0]  req1_x;
   logic [6:0]  req1_y;
   logic [23:0] req1_color;
   logic        req1_ready;

   logic        clear_start;
   logic [23:0] clear_color;
   logic        clear_busy;
   logic        clear_done;
   logic        oob_drop;

   logic [14:0] write_mem_address;
   logic [23:0] write_mem_data;
   logic        write_a_pixel;

   // Drawing side: presents pixels and clear requests, sees the results.
   modport master (
      output active_pixels,
      output req0_valid, req0_x, req0_y, req0_color,
      input  req0_ready,
      output req1_valid, req1_x, req1_y, req1_color,
      input  req1_ready,
      output clear_start, clear_color,
      input  clear_busy, clear_done, oob_drop,
      input  write_mem_address, write_mem_data, write_a_pixel
   );

   // Arbiter side.
   modport slave (
      input  active_pixels,
      input  req0_valid, req0_x, req0_y, req0_color,
      output req0_ready,
      input  req1_valid, req1_x, req1_y, req1_color,
      output req1_ready,
      input  clear_start, clear_color,
      output clear_busy, clear_done, oob_drop,
      output write_mem_address, write_mem_data, write_a_pixel
   );
endinterface

// File: rtl/frame_write_arbiter.sv
// Shares the draw-frame pixel-write port between two round-robin requesters
// and a full-frame clear engine, translating virtual (x,y) into the
// column-major address x*VIRTUAL_HEIGHT + y. Writes can be held to blanking.
module frame_write_arbiter #(
   parameter int VIRTUAL_WIDTH  = 160,
   parameter int VIRTUAL_HEIGHT = 120,
   parameter bit BLANK_ONLY     = 1'b1
) (
   input logic                  clk,
   input logic                  rst,
   frame_write_arbiter_if.slave bus
);
   localparam logic [0:0]  S_IDLE    = 1'b0;
   localparam logic [0:0]  S_CLEAR   = 1'b1;
   localparam logic [7:0]  X_LIMIT   = 8'(VIRTUAL_WIDTH);
   localparam logic [6:0]  Y_LIMIT   = 7'(VIRTUAL_HEIGHT);
   localparam logic [14:0] STRIDE    = 15'(VIRTUAL_HEIGHT);
   localparam logic [14:0] LAST_ADDR = 15'(VIRTUAL_WIDTH * VIRTUAL_HEIGHT - 1);

   logic [0:0]  state;
   logic        last_grant;   // 1 = requester 1 was granted last
   logic [14:0] counter;
   logic [23:0] fill_color;

   logic        allow;
   logic        serve;
   logic        grant0;
   logic        grant1;
   logic        accept0;
   logic        accept1;
   logic [7:0]  sel_x;
   logic [6:0]  sel_y;
   logic [23:0] sel_color;
   logic        in_range;
   logic [14:0] pixel_addr;

   assign allow = !BLANK_ONLY || !bus.active_pixels;

   // Arbitration and address translation for the pixel offered this cycle.
   // NOTE: every signal here is assigned on every path, so no latch can form.
   always_comb begin
      serve     = rst && (state == S_IDLE) && allow && !bus.clear_start;
      grant0    = bus.req0_valid && (!bus.req1_valid || last_grant);
      grant1    = bus.req1_valid && (!bus.req0_valid || !last_grant);
      accept0   = serve && grant0;
      accept1   = serve && grant1;
      sel_x     = accept1 ? bus.req1_x     : bus.req0_x;
      sel_y     = accept1 ? bus.req1_y     : bus.req0_y;
      sel_color = accept1 ? bus.req1_color : bus.req0_color;
      in_range  = (sel_x < X_LIMIT) && (sel_y < Y_LIMIT);
      // Constant stride: for 120 this reduces to (x<<7)-(x<<3)+y.
      pixel_addr = ({7'd0, sel_x} * STRIDE) + {8'd0, sel_y};
   end

   // Readies are gated by reset so nothing is offered while rst is low.
   assign bus.req0_ready = accept0;
   assign bus.req1_ready = accept1;

   // Sequencer: serves requesters in IDLE, walks the frame in CLEAR.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state                 <= S_IDLE;
         last_grant            <= 1'b1;
         counter               <= '0;
         fill_color            <= '0;
         bus.clear_busy        <= 1'b0;
         bus.clear_done        <= 1'b0;
         bus.oob_drop          <= 1'b0;
         bus.write_a_pixel     <= 1'b0;
         bus.write_mem_address <= '0;
         bus.write_mem_data    <= '0;
      end else begin
         bus.write_a_pixel <= 1'b0;
         bus.oob_drop      <= 1'b0;
         bus.clear_done    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.clear_start) begin
                  state          <= S_CLEAR;
                  fill_color     <= bus.clear_color;
                  counter        <= '0;
                  bus.clear_busy <= 1'b1;
               end else if (accept0 || accept1) begin
                  last_grant <= accept1;
                  if (in_range) begin
                     bus.write_a_pixel     <= 1'b1;
                     bus.write_mem_address <= pixel_addr;
                     bus.write_mem_data    <= sel_color;
                  end else begin
                     bus.oob_drop <= 1'b1;
                  end
               end
            end
            S_CLEAR: begin
               if (allow) begin
                  bus.write_a_pixel     <= 1'b1;
                  bus.write_mem_address <= counter;
                  bus.write_mem_data    <= fill_color;
                  if (counter == LAST_ADDR) begin
                     state          <= S_IDLE;
                     counter        <= '0;
                     bus.clear_busy <= 1'b0;
                     bus.clear_done <= 1'b1;
                  end else begin
                     counter <= counter + 15'd1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
